spi_dac_driver: RTL

Parametrised SPI transmitter for single-channel serial DACs (24-bit AD5683-style by default) on sysclk. It replaces the fixed free-running DAC shifter with a valid/ready word input, generic word width and SCLK divider, a configurable nSYNC gap and an optional auto-refresh mode. Words arrive from a Wishbone control register or a control loop; the outputs drive the spi_dac_* pins directly.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_tick.sv | 38 +++
 rtl/spi_dac_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI converter drivers: FSM state encoding and a
// constant-evaluable ceil(log2) used to size counters.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Enable-gated divider: o_tick pulses once every CLK_DIV enabled cycles, counter
// parks at zero while disabled so the first tick always lands CLK_DIV cycles in.
module spi_clk_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 11
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = CLOG2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_ctr_q, div_ctr_d;

  assign o_tick = i_en && (div_ctr_q == LAST);

  always_comb begin
    div_ctr_d = div_ctr_q;
    if (!i_en || o_tick) begin
      div_ctr_d = '0;
    end else begin
      div_ctr_d = div_ctr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_ctr_q <= '0;
    end else begin
      div_ctr_q <= div_ctr_d;
    end
  end

endmodule

// File: rtl/spi_dac_driver.sv
// SPI transmitter for single-channel serial DACs: one word per valid/ready
// handshake (or held-word refresh), MSB first, SCLK idles high, nSYNC gap after.
module spi_dac_driver
  import spi_pkg::*;
#(
  parameter int                    WORD_WIDTH = 24,
  parameter int                    CLK_DIV    = 11,
  parameter int                    SYNC_GAP   = 5,
  parameter logic [WORD_WIDTH-1:0] INIT_WORD  = WORD_WIDTH'(24'h007F22)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_refresh,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  output logic                  o_spi_sync_n
);

  localparam int BW = CLOG2(WORD_WIDTH) + 1;
  localparam int GW = CLOG2(2 * SYNC_GAP) + 1;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] held_q, held_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_ctr_q, bit_ctr_d;
  logic [GW-1:0]         gap_ctr_q, gap_ctr_d;
  logic                  sclk_q, sclk_d;
  logic                  done_q, done_d;
  logic                  tick;

  spi_clk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (state_q != IDLE),
    .o_tick(tick)
  );

  assign o_ready      = (state_q == IDLE) && !i_rst;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
  assign o_spi_sclk   = sclk_q;
  assign o_spi_sync_n = (state_q != SHIFT);
  assign o_spi_mosi   = (state_q == SHIFT) && shreg_q[WORD_WIDTH-1];

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    shreg_d   = shreg_q;
    bit_ctr_d = bit_ctr_q;
    gap_ctr_d = gap_ctr_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d    = 1'b1;
        bit_ctr_d = '0;
        gap_ctr_d = '0;
        if (i_valid) begin
          held_d  = i_data;
          shreg_d = i_data;
          state_d = SHIFT;
        end else if (i_refresh) begin
          shreg_d = held_q;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          // Only the rising edge advances the bit; the falling edge is the DAC's sample point.
          if (!sclk_q) begin
            bit_ctr_d = bit_ctr_q + 1'b1;
            if (bit_ctr_q == BW'(WORD_WIDTH - 1)) begin
              state_d   = GAP;
              gap_ctr_d = '0;
            end else begin
              shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_ctr_q == GW'(2 * SYNC_GAP - 1)) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            gap_ctr_d = '0;
          end else begin
            gap_ctr_d = gap_ctr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      held_q    <= INIT_WORD;
      shreg_q   <= '0;
      bit_ctr_q <= '0;
      gap_ctr_q <= '0;
      sclk_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      shreg_q   <= shreg_d;
      bit_ctr_q <= bit_ctr_d;
      gap_ctr_q <= gap_ctr_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
    end
  end

endmodule
